// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, FSM state type and index stepping helper for
// the PWM configuration controller.
//   F_IDX_MAX / D_IDX_MAX : upper limits of the frequency and duty indices
//   IDX_W                 : width of every index register
//   pwm_state_t           : controller FSM states
//   step_idx()            : saturating +/-1 step of an index
package pwm_pkg;

  localparam int F_IDX_MAX = 8;
  localparam int D_IDX_MAX = 10;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    APPLY     = 2'd2,
    RAMP      = 2'd3
  } pwm_state_t;

  // Up and down together cancel; limits hold the value instead of wrapping.
  function automatic logic [IDX_W-1:0] step_idx(
    input logic [IDX_W-1:0] cur,
    input logic             up,
    input logic             dn,
    input logic [IDX_W-1:0] max_v
  );
    logic [IDX_W-1:0] res;
    res = cur;
    if (up && !dn && (cur != max_v)) res = cur + IDX_W'(1);
    else if (dn && !up && (cur != '0)) res = cur - IDX_W'(1);
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus level debouncer for one raw button.
//   clk, rst : system clock, synchronous active-high reset
//   btn      : raw asynchronous button level
//   press    : one-cycle pulse when the button has been accepted as pressed
// A new level is accepted once the synchronized input has differed from the
// accepted level for DEB_CYCLES consecutive cycles; only a low->high
// acceptance emits a pulse, so the button must be seen stable low again
// before the next press can fire.
module btn_debounce #(
  parameter int DEB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync_2;
        cnt   <= '0;
        press <= sync_2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_config_ctrl.sv
// pwm_config_ctrl: turns four debounced buttons into frequency/duty indices
// for a PWM divider, changing the applied values only at period boundaries.
//   clk, rst              : system clock, synchronous active-high reset
//   btn_f_up / btn_f_dn   : raw buttons stepping the frequency target tf
//   btn_d_up / btn_d_dn   : raw buttons stepping the duty target td
//   period_end            : one-cycle strobe from the divider at a period end
//   bf, bc                : applied frequency (0..8) and duty (0..10) indices
//   busy                  : high whenever the FSM is not IDLE
//   dbg_state             : current FSM state, for observation only
// Strobe semantics: period_end and the internal press pulses are single-cycle
// strobes with no back-pressure; a strobe is consumed in the cycle it is seen
// or ignored (period_end in IDLE is ignored).
// Build option: define PWM_SOFT_START_EN to ramp bc from 0 up to td after
// every frequency change and after the first apply following reset.
module pwm_config_ctrl
  import pwm_pkg::*;
#(
  parameter int DEB_CYCLES   = 100000,
  parameter int RAMP_PERIODS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_f_up,
  input  logic             btn_f_dn,
  input  logic             btn_d_up,
  input  logic             btn_d_dn,
  input  logic             period_end,
  output logic [IDX_W-1:0] bf,
  output logic [IDX_W-1:0] bc,
  output logic             busy,
  output pwm_state_t       dbg_state
);

`ifdef PWM_SOFT_START_EN
  localparam bit SOFT_START = 1'b1;
`else
  localparam bit SOFT_START = 1'b0;
`endif

  localparam int RC_W = $clog2(RAMP_PERIODS + 1);

  logic p_fu, p_fd, p_du, p_dd;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fu (.clk(clk), .rst(rst), .btn(btn_f_up), .press(p_fu));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fd (.clk(clk), .rst(rst), .btn(btn_f_dn), .press(p_fd));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_du (.clk(clk), .rst(rst), .btn(btn_d_up), .press(p_du));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dd (.clk(clk), .rst(rst), .btn(btn_d_dn), .press(p_dd));

  // Targets follow presses in every state, so presses during WAIT_EDGE are
  // merged into the single upcoming APPLY.
  logic [IDX_W-1:0] tf, td;

  always_ff @(posedge clk) begin
    if (rst) begin
      tf <= '0;
      td <= '0;
    end else begin
      tf <= step_idx(tf, p_fu, p_fd, IDX_W'(F_IDX_MAX));
      td <= step_idx(td, p_du, p_dd, IDX_W'(D_IDX_MAX));
    end
  end

  pwm_state_t       state_q, state_d;
  logic [IDX_W-1:0] bf_d, bc_d;
  logic [RC_W-1:0]  ramp_cnt, ramp_cnt_d;
  logic             first_q, first_d;  // no APPLY seen since reset

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bf       <= '0;
      bc       <= '0;
      ramp_cnt <= '0;
      first_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      bf       <= bf_d;
      bc       <= bc_d;
      ramp_cnt <= ramp_cnt_d;
      first_q  <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bf_d       = bf;
    bc_d       = bc;
    ramp_cnt_d = ramp_cnt;
    first_d    = first_q;
    case (state_q)
      IDLE: begin
        if ((tf != bf) || (td != bc)) state_d = WAIT_EDGE;
      end
      WAIT_EDGE: begin
        if (period_end) state_d = APPLY;
      end
      APPLY: begin
        bf_d    = tf;
        first_d = 1'b0;
        if (SOFT_START && ((tf != bf) || first_q)) begin
          bc_d       = '0;
          ramp_cnt_d = '0;
          state_d    = RAMP;
        end else begin
          bc_d    = td;
          state_d = IDLE;
        end
      end
      RAMP: begin
        if (bc == td) begin
          state_d = IDLE;
        end else if (period_end) begin
          if (ramp_cnt == RC_W'(RAMP_PERIODS - 1)) begin
            ramp_cnt_d = '0;
            // A td that dropped below bc during the ramp is taken directly.
            bc_d = (bc > td) ? td : bc + IDX_W'(1);
            if (bc_d == td) state_d = IDLE;
          end else begin
            ramp_cnt_d = ramp_cnt + RC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pwm_config_ctrl.sv
// tb_pwm_config_ctrl: directed scenarios plus randomized button/period_end
// traffic, checked every cycle against a behavioural model of the controller.
module tb_pwm_config_ctrl;
  import pwm_pkg::*;

  localparam int DEB = 4;
  localparam int RP  = 2;
`ifdef PWM_SOFT_START_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] btn = 4'b0000;  // 0 f_up, 1 f_dn, 2 d_up, 3 d_dn
  logic period_end = 1'b0;
  logic [3:0] bf, bc;
  logic busy;
  pwm_state_t dbg_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_config_ctrl #(.DEB_CYCLES(DEB), .RAMP_PERIODS(RP)) dut (
    .clk(clk), .rst(rst),
    .btn_f_up(btn[0]), .btn_f_dn(btn[1]), .btn_d_up(btn[2]), .btn_d_dn(btn[3]),
    .period_end(period_end),
    .bf(bf), .bc(bc), .busy(busy), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Debounce: a press is recognised when the raw level has been high for DEB
  // consecutive samples after having been accepted low; it reaches the target
  // registers three edges later (two sync stages plus the pulse register).
  int  hi_run[4], lo_run[4];
  bit  lvl[4];
  bit  pipe[4][3];
  bit  deliv[4];
  int  m_tf, m_td, m_bf, m_bc, m_rcnt, o_tf, o_td, o_bf, o_bc, nb;
  bit  m_busy, m_wait, m_apply, m_ramp, m_first, m_valid;

  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        hi_run[b] = 0; lo_run[b] = 0; lvl[b] = 1'b0;
        for (int s = 0; s < 3; s++) pipe[b][s] = 1'b0;
      end
      m_tf = 0; m_td = 0; m_bf = 0; m_bc = 0; m_rcnt = 0;
      m_busy = 0; m_wait = 0; m_apply = 0; m_ramp = 0; m_first = 1;
      m_valid = 1'b1;
    end else begin
      for (int b = 0; b < 4; b++) begin
        deliv[b]   = pipe[b][2];
        pipe[b][2] = pipe[b][1];
        pipe[b][1] = pipe[b][0];
        pipe[b][0] = 1'b0;
        if (btn[b]) begin hi_run[b]++; lo_run[b] = 0; end
        else begin lo_run[b]++; hi_run[b] = 0; end
        if (!lvl[b] && hi_run[b] >= DEB) begin lvl[b] = 1'b1; pipe[b][0] = 1'b1; end
        else if (lvl[b] && lo_run[b] >= DEB) lvl[b] = 1'b0;
      end
      o_tf = m_tf; o_td = m_td; o_bf = m_bf; o_bc = m_bc;
      if (!m_busy) begin
        if (o_tf != o_bf || o_td != o_bc) begin m_busy = 1; m_wait = 1; end
      end else if (m_wait) begin
        if (period_end) begin m_wait = 0; m_apply = 1; end
      end else if (m_apply) begin
        m_apply = 0;
        m_bf = o_tf;
        if (SOFT && (o_tf != o_bf || m_first)) begin m_bc = 0; m_ramp = 1; m_rcnt = 0; end
        else begin m_bc = o_td; m_busy = 0; end
        m_first = 0;
      end else if (m_ramp) begin
        if (o_bc == o_td) begin m_ramp = 0; m_busy = 0; end
        else if (period_end) begin
          m_rcnt++;
          if (m_rcnt == RP) begin
            m_rcnt = 0;
            nb = (o_bc + 1 < o_td) ? o_bc + 1 : o_td;
            m_bc = nb;
            if (nb == o_td) begin m_ramp = 0; m_busy = 0; end
          end
        end
      end
      if (deliv[0] != deliv[1])
        m_tf = deliv[0] ? ((o_tf < F_IDX_MAX) ? o_tf + 1 : o_tf) : ((o_tf > 0) ? o_tf - 1 : o_tf);
      if (deliv[2] != deliv[3])
        m_td = deliv[2] ? ((o_td < D_IDX_MAX) ? o_td + 1 : o_td) : ((o_td > 0) ? o_td - 1 : o_td);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("model_bf", bf, m_bf);
      check("model_bc", bc, m_bc);
      check("model_busy", busy, m_busy);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press(input int b);
    btn[b] = 1'b1;
    repeat (6) @(negedge clk);
    btn[b] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pe_pulse();
    @(negedge clk) period_end = 1'b1;
    @(negedge clk) period_end = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; btn = 4'b0000; period_end = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      pe_pulse();
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_bf", bf, 0);
    check("reset_bc", bc, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;

    // 3-cycle glitch is filtered
    btn[0] = 1'b1; repeat (3) @(negedge clk); btn[0] = 1'b0;
    repeat (10) @(negedge clk);
    pe_pulse(); @(negedge clk);
    check("glitch_bf", bf, 0);
    check("glitch_busy", busy, 0);

    // 10-cycle hold, then bf lands one cycle after the period_end is taken
    btn[0] = 1'b1; repeat (10) @(negedge clk); btn[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("hold_busy", busy, 1);
    pe_pulse();
    check("hold_bf_at_pe", bf, 0);
    @(negedge clk);
    check("hold_bf_after", bf, 1);
    wait_idle();

    // saturation at 0 for frequency
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press(1);
      check("fdn_busy", busy, 0);
    end
    check("fdn_bf", bf, 0);

    // saturation at 10 for duty
    for (int i = 0; i < 12; i++) press(2);
    wait_idle();
    check("dup_sat_bc", bc, 10);

    // merging: three presses, one update 0 -> 3
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press(0);
      check("merge_busy", busy, 1);
      check("merge_bf_hold", bf, 0);
    end
    pe_pulse();
    check("merge_bf_at_pe", bf, 0);
    check("merge_busy_apply", busy, 1);
    @(negedge clk);
    check("merge_bf_after", bf, 3);
    wait_idle();

    // conflicting duty presses cancel, frequency press still applies
    press(2); press(2);
    wait_idle();
    check("conf_bc_pre", bc, 2);
    btn = 4'b1101;
    repeat (6) @(negedge clk);
    btn = 4'b0000;
    repeat (6) @(negedge clk);
    wait_idle();
    check("conf_bf", bf, 4);
    check("conf_bc", bc, 2);

`ifdef PWM_SOFT_START_EN
    // soft-start ramp 0..5, one step per RP period_end pulses
    do_reset();
    for (int i = 0; i < 5; i++) press(2);
    press(0);
    pe_pulse();
    @(negedge clk);
    check("ramp_bf", bf, 1);
    check("ramp_bc_start", bc, 0);
    for (int k = 1; k <= 10; k++) begin
      pe_pulse();
      check("ramp_bc_step", bc, ((k / RP) < 5) ? (k / RP) : 5);
      check("ramp_busy", busy, (k < 10) ? 1 : 0);
    end

    // reset in the middle of a ramp
    do_reset();
    for (int i = 0; i < 3; i++) press(2);
    press(0);
    pe_pulse();
    repeat (4) pe_pulse();
    check("rst_ramp_bc_pre", bc, 2);
    check("rst_ramp_busy_pre", busy, 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("rst_ramp_bf", bf, 0);
    check("rst_ramp_bc", bc, 0);
    check("rst_ramp_busy", busy, 0);
    rst = 1'b0;
`else
    // reset while waiting for a period edge
    do_reset();
    press(2);
    check("rst_wait_busy_pre", busy, 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("rst_wait_bf", bf, 0);
    check("rst_wait_bc", bc, 0);
    check("rst_wait_busy", busy, 0);
    rst = 1'b0;
`endif

    // randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
      period_end = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 999) == 0);
    end
    @(negedge clk);
    btn = 4'b0000; period_end = 1'b0; rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_config_ctrl.md
PWM_CONFIG_CTRL -- requirements
Module: pwm_config_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 100000, the number of stable clk cycles required to accept a button level.
REQ-002 SHALL have parameter RAMP_PERIODS, default 16, the number of PWM periods per duty step during soft-start.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port btn_f_up, input, 1, raw asynchronous button for frequency index up.
REQ-006 SHALL have port btn_f_dn, input, 1, raw asynchronous button for frequency index down.
REQ-007 SHALL have port btn_d_up, input, 1, raw asynchronous button for duty index up.
REQ-008 SHALL have port btn_d_dn, input, 1, raw asynchronous button for duty index down.
REQ-009 SHALL have port period_end, input, 1, a one-cycle pulse from the divider marking a PWM period boundary.
REQ-010 SHALL have port bf, output, 4, the applied frequency index (0..8) driven to the divider.
REQ-011 SHALL have port bc, output, 4, the applied duty index (0..10) driven to the divider.
REQ-012 SHALL have port busy, output, 1, high while a target differs from the applied value.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer and debounce it, emitting one press pulse when the synchronized level has been stable high for DEB_CYCLES cycles, re-armed only after the level has been stable low for DEB_CYCLES cycles.
REQ-014 SHALL hold target registers tf (0..8) and td (0..10); a press increments or decrements the corresponding target, saturating at 0 and at its maximum (no wrap).
REQ-015 SHALL ignore both press pulses when up and down for the same field pulse in the same cycle; presses on different fields in the same cycle SHALL both be applied.
REQ-016 SHALL implement an FSM with states IDLE, WAIT_EDGE, APPLY and RAMP.
REQ-017 SHALL transition IDLE->WAIT_EDGE when tf!=bf or td!=bc.
REQ-018 SHALL transition WAIT_EDGE->APPLY on period_end.
REQ-019 SHALL, in APPLY (one cycle), load bf<=tf, then go to RAMP if soft-start is active, else load bc<=td and return to IDLE.
REQ-020 SHALL never change bf or bc except in the APPLY or RAMP states, so that each update lands in the cycle after a period_end.
REQ-021 SHALL merge presses arriving in WAIT_EDGE into the targets, so the latest targets are applied by a single APPLY.
REQ-022 SHALL drive busy high in WAIT_EDGE, APPLY and RAMP, and low in IDLE.
REQ-023 SHALL ignore a period_end that arrives in IDLE.

Reset
REQ-024 SHALL, on rst, set bf=0, bc=0, tf=0, td=0, busy=0 and FSM=IDLE, and clear all debounce counters and pulse outputs.
REQ-025 SHALL let rst asserted mid-ramp or mid-wait override everything in the same clock edge; no pending update survives reset.

Configuration
REQ-026 SHALL, with macro PWM_SOFT_START_EN defined, enter RAMP after every APPLY in which bf changed or which is the first APPLY after reset; RAMP SHALL set bc<=0, then increment bc by 1 every RAMP_PERIODS period_end pulses until bc==td, then return to IDLE; a td decrease during RAMP SHALL clamp bc to td at the next step.
REQ-027 SHALL, without PWM_SOFT_START_EN, never enter the RAMP state and load bc directly in APPLY.

Structure
REQ-028 SHALL place constants F_IDX_MAX=8, D_IDX_MAX=10 and the FSM state enum in shared package pwm_pkg.
REQ-029 SHALL implement debouncing in sub-module btn_debounce (sync + counter + press pulse), instantiated four times.

Verification (bench uses DEB_CYCLES=4, RAMP_PERIODS=2)
REQ-030 SHALL verify debounce: a 3-cycle glitch on btn_f_up produces no change; a 10-cycle hold followed by a period_end produces bf=1 exactly one cycle after period_end.
REQ-031 SHALL verify saturation: 12 btn_d_up presses with soft-start off produce bc=10; 3 btn_f_dn presses from reset leave bf=0 and busy=0.
REQ-032 SHALL verify merging: 3 btn_f_up presses before any period_end produce bf stepping 0->3 in a single update, with busy high from the first press until the apply.
REQ-033 SHALL verify conflicts: btn_d_up and btn_d_dn accepted in the same cycle leave td unchanged, while a simultaneous btn_f_up is still applied.
REQ-034 SHALL verify soft-start on: with td=5 and a change of bf, bc steps 0,1,2,3,4,5 on every 2nd period_end and busy falls once bc==5.
REQ-035 SHALL verify reset: rst asserted during RAMP at bc=2 yields bf=0, bc=0, busy=0 on the next cycle.
